// File: rtl/gpio_irq_pkg.sv
// Shared register map, pin mode encodings and field offsets for the gpio_irq block.
package gpio_irq_pkg;

    localparam logic [3:0] GPIO_CTRL     = 4'h0;
    localparam logic [3:0] GPIO_DATA     = 4'h4;
    localparam logic [3:0] GPIO_INT_EN   = 4'h8;
    localparam logic [3:0] GPIO_INT_PEND = 4'hC;

    // 2'b11 is reserved and treated exactly like hi-Z.
    typedef enum logic [1:0] {
        MODE_HIZ = 2'b00,
        MODE_OUT = 2'b01,
        MODE_IN  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    localparam int unsigned FALL_OFS = 16;

endpackage

// File: rtl/gpio_sync.sv
// One-bit multi-flop synchroniser for an asynchronous pad input.
// Latency: STAGES clk edges from d to q; no flow control.
module gpio_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO controller: per-pin mode, synchronised inputs, sticky edge interrupts, level irq.
// Writes take effect next cycle, reads are combinational; the bus never stalls.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int NUM_IO      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    input  logic [NUM_IO-1:0] io_pin_i,
    output logic [NUM_IO-1:0] io_pin_o,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic              irq_o
);

    logic [2*NUM_IO-1:0] ctrl;
    logic [NUM_IO-1:0]   data;
    logic [NUM_IO-1:0]   rise_en;
    logic [NUM_IO-1:0]   fall_en;
    logic [NUM_IO-1:0]   rise_pend;
    logic [NUM_IO-1:0]   fall_pend;
    logic [NUM_IO-1:0]   sync;
    logic [NUM_IO-1:0]   prev;
    logic [NUM_IO-1:0]   is_in;
    logic [NUM_IO-1:0]   is_out;
    logic [NUM_IO-1:0]   rise;
    logic [NUM_IO-1:0]   fall;
    logic [NUM_IO-1:0]   rise_clr;
    logic [NUM_IO-1:0]   fall_clr;
    logic [NUM_IO-1:0]   data_wr;
    logic [3:0]          offset;
    logic                wr_ctrl;
    logic                wr_data;
    logic                wr_en;
    logic                wr_pend;
    logic                unused_bits;

    assign offset  = addr_i[3:0];
    assign wr_ctrl = we_i && (offset == GPIO_CTRL);
    assign wr_data = we_i && (offset == GPIO_DATA);
    assign wr_en   = we_i && (offset == GPIO_INT_EN);
    assign wr_pend = we_i && (offset == GPIO_INT_PEND);

    genvar g;
    generate
        for (g = 0; g < NUM_IO; g++) begin : g_pin
            gpio_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (io_pin_i[g]),
                .q     (sync[g])
            );
            assign is_in[g]  = (ctrl[2*g +: 2] == MODE_IN);
            assign is_out[g] = (ctrl[2*g +: 2] == MODE_OUT);
        end
    endgenerate

    // Edges are seen on every pin regardless of mode; only the enables gate recording.
    assign rise     = sync & ~prev;
    assign fall     = ~sync & prev;
    assign rise_clr = wr_pend ? data_i[NUM_IO-1:0] : '0;
    assign fall_clr = wr_pend ? data_i[FALL_OFS +: NUM_IO] : '0;
    assign data_wr  = wr_data ? data_i[NUM_IO-1:0] : data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl      <= '0;
            data      <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
            prev      <= '0;
        end else begin
            prev <= sync;
            if (wr_ctrl) begin
                ctrl <= data_i[2*NUM_IO-1:0];
            end
            // Input pins track the pad; CPU writes only land on the other pins.
            data <= (is_in & sync) | (~is_in & data_wr);
            if (wr_en) begin
                rise_en <= data_i[NUM_IO-1:0];
                fall_en <= data_i[FALL_OFS +: NUM_IO];
            end
            // A same-cycle hardware set beats the W1C.
            rise_pend <= (rise & rise_en) | (rise_pend & ~rise_clr);
            fall_pend <= (fall & fall_en) | (fall_pend & ~fall_clr);
        end
    end

    always_comb begin
        data_o = '0;
        case (offset)
            GPIO_CTRL: data_o[2*NUM_IO-1:0] = ctrl;
            GPIO_DATA: data_o[NUM_IO-1:0]   = data;
            GPIO_INT_EN: begin
                data_o[NUM_IO-1:0]          = rise_en;
                data_o[FALL_OFS +: NUM_IO]  = fall_en;
            end
            GPIO_INT_PEND: begin
                data_o[NUM_IO-1:0]          = rise_pend;
                data_o[FALL_OFS +: NUM_IO]  = fall_pend;
            end
            default: data_o = '0;
        endcase
    end

    assign io_oe_o  = is_out;
    assign io_pin_o = data & is_out;
    assign irq_o    = (|rise_pend) | (|fall_pend);

    assign unused_bits = ^{addr_i[31:4], data_i};

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq (4 pins, 2-stage sync): reference model compared every cycle plus directed literals.
module tb_gpio_irq;

    localparam int N = 4;
    localparam int S = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          we    = 1'b0;
    logic [31:0]   addr  = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   data_o;
    logic [N-1:0]  pad   = '0;
    logic [N-1:0]  pin_o;
    logic [N-1:0]  oe_o;
    logic          irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_irq #(.NUM_IO(N), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (wdata),
        .data_o   (data_o),
        .io_pin_i (pad),
        .io_pin_o (pin_o),
        .io_oe_o  (oe_o),
        .irq_o    (irq)
    );

    // Reference model: architectural state per pin, pad history as a delay line.
    logic [1:0]   m_mode [N];
    logic [N-1:0] m_hist [S];
    logic [N-1:0] m_data, m_ren, m_fen, m_rp, m_fp, m_prev, m_sync;
    logic [1:0]   n_mode [N];
    logic [N-1:0] n_data, n_ren, n_fen, n_rp, n_fp;

    assign m_sync = m_hist[S-1];

    always_comb begin
        n_data = m_data;
        n_ren  = m_ren;
        n_fen  = m_fen;
        n_rp   = m_rp;
        n_fp   = m_fp;
        for (int i = 0; i < N; i++) n_mode[i] = m_mode[i];
        for (int i = 0; i < N; i++) begin
            if (we && addr[3:0] == 4'h0) n_mode[i] = wdata[2*i +: 2];
            if (m_mode[i] == 2'b10) n_data[i] = m_sync[i];
            else if (we && addr[3:0] == 4'h4) n_data[i] = wdata[i];
            if (we && addr[3:0] == 4'h8) begin
                n_ren[i] = wdata[i];
                n_fen[i] = wdata[16+i];
            end
            if (m_sync[i] && !m_prev[i] && m_ren[i]) n_rp[i] = 1'b1;
            else if (we && addr[3:0] == 4'hC && wdata[i]) n_rp[i] = 1'b0;
            if (!m_sync[i] && m_prev[i] && m_fen[i]) n_fp[i] = 1'b1;
            else if (we && addr[3:0] == 4'hC && wdata[16+i]) n_fp[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_mode[i] <= 2'b00;
            for (int k = 0; k < S; k++) m_hist[k] <= '0;
            m_data <= '0; m_ren <= '0; m_fen <= '0;
            m_rp   <= '0; m_fp  <= '0; m_prev <= '0;
        end else begin
            for (int i = 0; i < N; i++) m_mode[i] <= n_mode[i];
            m_hist[0] <= pad;
            for (int k = 1; k < S; k++) m_hist[k] <= m_hist[k-1];
            m_data <= n_data; m_ren <= n_ren; m_fen <= n_fen;
            m_rp   <= n_rp;   m_fp  <= n_fp;  m_prev <= m_sync;
        end
    end

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            4'h0: for (int i = 0; i < N; i++) r = r | (32'(m_mode[i]) << (2*i));
            4'h4: r = 32'(m_data);
            4'h8: r = 32'(m_ren) | (32'(m_fen) << 16);
            4'hC: r = 32'(m_rp) | (32'(m_fp) << 16);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] m_oe();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_mode[i] == 2'b01);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_data_o", data_o, m_read(addr[3:0]));
        check("cyc_oe", 32'(oe_o), 32'(m_oe()));
        check("cyc_pin", 32'(pin_o), 32'(m_oe() & m_data));
        check("cyc_irq", 32'(irq), 32'((|m_rp) | (|m_fp)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, data_o, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(32'h0, 32'h0, "rst_ctrl");
        rd(32'hC, 32'h0, "rst_pend");
        check("rst_oe", 32'(oe_o), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        tick();

        // Output mode
        wr(32'h0, 32'h55);
        check("out_oe", 32'(oe_o), 32'hF);
        wr(32'h4, 32'hA);
        check("out_pin", 32'(pin_o), 32'hA);
        wr(32'h0, 32'h0);
        check("hiz_oe", 32'(oe_o), 32'h0);
        check("hiz_pin", 32'(pin_o), 32'h0);
        rd(32'h4, 32'hA, "data_kept");
        tick();

        // Input synchroniser latency on pin 0
        wr(32'h0, 32'h2);
        pad = 4'h1;
        tick();
        tick();
        rd(32'h4, 32'hA, "sync_early");
        tick();
        rd(32'h4, 32'hB, "sync_arrive");
        tick();
        wr(32'h4, 32'h0);
        rd(32'h4, 32'h1, "in_wr_ignored");
        tick();

        // Rising-edge interrupt
        wr(32'h8, 32'h1);
        pad = 4'h0;
        repeat (4) tick();
        pad = 4'h1;
        tick();
        tick();
        rd(32'hC, 32'h0, "rise_early");
        tick();
        rd(32'hC, 32'h1, "rise_pend");
        check("rise_irq", 32'(irq), 32'h1);
        tick();
        wr(32'hC, 32'h1);
        rd(32'hC, 32'h0, "rise_w1c");
        check("rise_irq_clr", 32'(irq), 32'h0);
        tick();

        // Falling edge timed against a W1C of the same bit
        wr(32'h8, 32'h10000);
        pad = 4'h0;
        tick();
        tick();
        wr(32'hC, 32'h10000);
        rd(32'hC, 32'h10000, "fall_set_wins");
        check("fall_irq", 32'(irq), 32'h1);
        tick();
        wr(32'h8, 32'h0);
        rd(32'hC, 32'h10000, "en_clr_keeps_pend");
        tick();
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'hC, 32'h0, "fall_w1c");
        check("fall_irq_clr", 32'(irq), 32'h0);
        tick();

        // Unstored bits, reserved mode, unmapped offsets
        wr(32'h0, 32'hFFFF_FFFF);
        rd(32'h0, 32'hFF, "ctrl_width");
        check("rsv_oe", 32'(oe_o), 32'h0);
        tick();
        wr(32'h4, 32'hFFFF_FFFF);
        rd(32'h4, 32'hF, "data_width");
        check("rsv_pin", 32'(pin_o), 32'h0);
        tick();
        wr(32'h8, 32'hFFFF_FFFF);
        rd(32'h8, 32'h000F_000F, "en_width");
        tick();
        wr(32'h8, 32'h0);
        wr(32'h2, 32'h55);
        rd(32'h0, 32'hFF, "unmapped_wr");
        rd(32'h2, 32'h0, "unmapped_rd");
        tick();
        wr(32'h10, 32'h100);
        rd(32'h10, 32'h0, "alias_rd");
        rd(32'h0, 32'h0, "alias_ctrl");
        tick();

        // Mid-run reset with pending interrupts
        wr(32'h0, 32'h55);
        wr(32'h8, 32'h000F_000F);
        pad = 4'hF;
        repeat (3) tick();
        rd(32'hC, 32'hF, "pre_rst_pend");
        check("pre_rst_irq", 32'(irq), 32'h1);
        tick();
        rst_n = 1'b0;
        rd(32'h0, 32'h0, "mid_rst_ctrl");
        rd(32'h4, 32'h0, "mid_rst_data");
        rd(32'h8, 32'h0, "mid_rst_en");
        rd(32'hC, 32'h0, "mid_rst_pend");
        check("mid_rst_oe", 32'(oe_o), 32'h0);
        check("mid_rst_pin", 32'(pin_o), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rd(32'hC, 32'h0, "post_rst_rise_ignored");
        check("post_rst_irq", 32'(irq), 32'h0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
